// File: rtl/cache_types.sv
// Shared types and constants for the L1 data cache.
package cache_types;
  localparam int LINE_BYTES = 32;
  localparam int LINE_WORDS = 8;

  typedef enum logic [2:0] {IDLE, CHECK, RESP, WB, ALLOC} cache_state_t;
  typedef logic [LINE_BYTES*8-1:0] cache_line_t;
endpackage

// File: rtl/dcache_array.sv
// Per-set storage: tag/valid/dirty/data flops with a combinational read port,
// a full-line fill port and a byte-masked word write port.
module dcache_array
  import cache_types::*;
#(
  parameter int S_INDEX = 3,
  parameter int S_TAG   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [S_INDEX-1:0] index,
  output logic [S_TAG-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [255:0]       rd_line,
  input  logic               line_we,
  input  logic [S_TAG-1:0]   line_tag,
  input  logic [255:0]       line_data,
  input  logic               word_we,
  input  logic [2:0]         word_sel,
  input  logic [3:0]         word_be,
  input  logic [31:0]        word_data,
  input  logic               clean
);
  localparam int SETS = 2**S_INDEX;

  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;
  logic [S_TAG-1:0] tag_q  [SETS];
  cache_line_t      data_q [SETS];

  assign rd_tag   = tag_q[index];
  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_line  = data_q[index];

  // Only the status bits are reset; tag and data contents are meaningless until valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we && (word_be != 4'b0000)) begin
      dirty_q[index] <= 1'b1;
    end else if (clean) begin
      dirty_q[index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[index]  <= line_tag;
      data_q[index] <= line_data;
    end else if (word_we) begin
      for (int b = 0; b < 4; b++) begin
        if (word_be[b]) data_q[index][{word_sel, b[1:0], 3'b000} +: 8] <= word_data[8*b +: 8];
      end
    end
  end
endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back, write-allocate L1 data cache: CPU word port in,
// 256-bit line port out.
module l1_dcache
  import cache_types::*;
#(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5,
  parameter int S_TAG    = 32 - S_INDEX - S_OFFSET
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);
  cache_state_t state;

  logic [S_INDEX-1:0]            idx;
  logic [S_TAG-1:0]              tag;
  logic [$clog2(LINE_WORDS)-1:0] word_sel;
  logic                          unused_addr;
  logic [S_TAG-1:0]              way_tag;
  logic                          way_valid;
  logic                          way_dirty;
  logic [255:0]                  way_line;
  logic                          hit;
  logic                          fill_we;
  logic                          word_we;
  logic                          clean;

  assign idx         = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign tag         = mem_address[31:32-S_TAG];
  assign word_sel    = mem_address[S_OFFSET-1:2];
  assign unused_addr = ^mem_address[1:0];

  assign hit     = way_valid && (way_tag == tag);
  assign fill_we = (state == ALLOC) && pmem_resp;
  assign word_we = (state == CHECK) && hit && mem_write;
  assign clean   = (state == WB) && pmem_resp;

  dcache_array #(.S_INDEX(S_INDEX), .S_TAG(S_TAG)) u_array (
    .clk       (clk),
    .rst       (rst),
    .index     (idx),
    .rd_tag    (way_tag),
    .rd_valid  (way_valid),
    .rd_dirty  (way_dirty),
    .rd_line   (way_line),
    .line_we   (fill_we),
    .line_tag  (tag),
    .line_data (pmem_rdata),
    .word_we   (word_we),
    .word_sel  (word_sel),
    .word_be   (mem_byte_enable),
    .word_data (mem_wdata),
    .clean     (clean)
  );

  // A fill returns to CHECK so every request completes through the hit path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      mem_rdata    <= '0;
      mem_resp     <= 1'b0;
      pmem_address <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_wdata   <= '0;
    end else begin
      mem_resp <= 1'b0;
      case (state)
        IDLE: if (mem_read || mem_write) state <= CHECK;
        CHECK: begin
          if (hit) begin
            mem_rdata <= way_line[{word_sel, 5'b00000} +: 32];
            mem_resp  <= 1'b1;
            state     <= RESP;
          end else if (way_valid && way_dirty) begin
            pmem_write   <= 1'b1;
            pmem_address <= {way_tag, idx, {S_OFFSET{1'b0}}};
            pmem_wdata   <= way_line;
            state        <= WB;
          end else begin
            pmem_read    <= 1'b1;
            pmem_address <= {tag, idx, {S_OFFSET{1'b0}}};
            state        <= ALLOC;
          end
        end
        RESP: state <= IDLE;
        WB: if (pmem_resp) begin
          pmem_write   <= 1'b0;
          pmem_read    <= 1'b1;
          pmem_address <= {tag, idx, {S_OFFSET{1'b0}}};
          state        <= ALLOC;
        end
        ALLOC: if (pmem_resp) begin
          pmem_read <= 1'b0;
          state     <= CHECK;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_dcache.sv
// Bench for l1_dcache: memory-level reference model (CPU view vs backing store),
// a line-memory responder, and a per-cycle response/port monitor.
module tb_l1_dcache;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  l1_dcache dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
    int           wait_c;
  } pmem_op_t;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];      // {due cycle, expected rdata}
  pmem_op_t    op_q[$];
  int          resp_cnt = 0;
  int          last_cyc = 0;
  logic [31:0] last_rdata = '0;
  int          n_rd = 0;
  int          n_wr = 0;
  logic [31:0] last_rd_addr = '0;
  logic [31:0] last_wr_addr = '0;
  logic [255:0] last_wr_data = '0;
  int          fw_force = -1;

  // Reference model: what the CPU should see, what memory holds, and which line each set holds.
  logic [255:0] back_mem [logic [31:0]];
  logic [255:0] cpu_view [logic [31:0]];
  logic         res_valid [8];
  logic         res_dirty [8];
  logic [23:0]  res_tag   [8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = la ^ (32'h9E37_79B9 * 32'(w + 1));
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    return back_mem.exists(la) ? back_mem[la] : init_line(la);
  endfunction

  function automatic logic [255:0] view_line(input logic [31:0] la);
    return cpu_view.exists(la) ? cpu_view[la] : mem_line(la);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      res_valid[s] = 1'b0;
      res_dirty[s] = 1'b0;
      res_tag[s]   = '0;
    end
    cpu_view.delete();
  endtask

  task automatic model_req(input logic [31:0] a, input logic wr, input logic [3:0] be,
                           input logic [31:0] wd, output int lat, output logic [31:0] er);
    logic [2:0]   set;
    logic [23:0]  tg;
    logic [31:0]  la;
    logic [31:0]  victim;
    logic [255:0] line;
    pmem_op_t     op;
    int           fw;
    int           ww;
    set = a[7:5];
    tg  = a[31:8];
    la  = {a[31:5], 5'b00000};
    if (res_valid[set] && res_tag[set] == tg) begin
      lat = 2;
    end else begin
      fw = (fw_force >= 0) ? fw_force : int'($urandom_range(0, 3));
      if (res_valid[set] && res_dirty[set]) begin
        victim    = {res_tag[set], set, 5'b00000};
        ww        = $urandom_range(0, 3);
        op.wr     = 1'b1;
        op.addr   = victim;
        op.data   = view_line(victim);
        op.wait_c = ww;
        op_q.push_back(op);
        back_mem[victim] = view_line(victim);
        cpu_view.delete(victim);
        lat = 5 + ww + fw;
      end else begin
        lat = 4 + fw;
      end
      op.wr     = 1'b0;
      op.addr   = la;
      op.data   = mem_line(la);
      op.wait_c = fw;
      op_q.push_back(op);
      res_valid[set] = 1'b1;
      res_dirty[set] = 1'b0;
      res_tag[set]   = tg;
    end
    line = view_line(la);
    er   = line[{a[4:2], 5'b00000} +: 32];
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) line[{a[4:2], b[1:0], 3'b000} +: 8] = wd[8*b +: 8];
      cpu_view[la] = line;
      if (be != 4'b0000) res_dirty[set] = 1'b1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic [31:0] a, input logic rd, input logic wr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rdata, output int lat);
    int          exp_lat;
    logic [31:0] er;
    int          start;
    int          target;
    logic        got;
    model_req(a, wr, be, wd, exp_lat, er);
    @(posedge clk); #1;
    start = cyc;
    exp_q.push_back({32'(start + exp_lat), er});
    mem_address     = a;
    mem_read        = rd;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    target = resp_cnt + 1;
    got    = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk); #1;
      if (resp_cnt >= target) got = 1'b1;
    end
    chk("resp_timeout", {63'b0, got}, 64'd1);
    if (!got) begin
      exp_q.delete();
      op_q.delete();
    end
    rdata = last_rdata;
    lat   = last_cyc - start;
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // ---------------- monitor: responses and port rules ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      if (pmem_read || pmem_write) chk("pmem_rd_wr_excl", {63'b0, pmem_read && pmem_write}, 64'd0);
      if (mem_resp) begin
        resp_cnt++;
        last_rdata = mem_rdata;
        last_cyc   = cyc;
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", {32'b0, mem_rdata}, {32'b0, e[31:0]});
          chk("resp_cycle", 64'(cyc), {32'b0, e[63:32]});
        end
      end
    end
  end

  // ---------------- line memory responder ----------------
  initial begin
    pmem_op_t op;
    logic     skip;
    logic     aborted;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    skip       = 1'b0;
    forever begin
      if (!skip) @(negedge clk);
      skip = 1'b0;
      if (rst && (pmem_read || pmem_write)) begin
        if (op_q.size() == 0) begin
          chk("pmem_unexpected", {pmem_write, pmem_address}, 64'd0);
          op.wr = pmem_write; op.addr = pmem_address; op.data = '0; op.wait_c = 0;
        end else begin
          op = op_q.pop_front();
          chk("pmem_kind", {63'b0, pmem_write}, {63'b0, op.wr});
          chk("pmem_addr", {32'b0, pmem_address}, {32'b0, op.addr});
          if (op.wr) begin
            n_checks++;
            if (pmem_wdata !== op.data) begin
              n_fail++;
              $display("FAIL pmem_wdata got=%0h exp=%0h", pmem_wdata, op.data);
            end
          end
        end
        if (pmem_write) begin
          n_wr++;
          last_wr_addr = pmem_address;
          last_wr_data = pmem_wdata;
        end else begin
          n_rd++;
          last_rd_addr = pmem_address;
        end
        aborted = 1'b0;
        for (int i = 0; i < op.wait_c && !aborted; i++) begin
          @(negedge clk);
          if (!rst) aborted = 1'b1;
        end
        if (!aborted && rst) begin
          pmem_rdata = op.wr ? '0 : op.data;
          pmem_resp  = 1'b1;
          @(negedge clk);
          pmem_resp  = 1'b0;
          skip       = 1'b1;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0]  rd;
    int           lat;
    int           nrd0;
    int           nwr0;
    logic [255:0] l;
    pmem_op_t     op;
    logic         seen;
    logic [31:0]  a;
    int           k;

    rst = 1'b0;
    mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = '0; mem_wdata = '0;
    model_reset();
    l = init_line(32'h0000_1000);
    l[63:32] = 32'hDEAD_BEEF;
    back_mem[32'h0000_1000] = l;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_resp",   {63'b0, mem_resp}, 64'd0);
    chk("rst_mem_rdata",  {32'b0, mem_rdata}, 64'd0);
    chk("rst_pmem_read",  {63'b0, pmem_read}, 64'd0);
    chk("rst_pmem_write", {63'b0, pmem_write}, 64'd0);
    chk("rst_pmem_addr",  {32'b0, pmem_address}, 64'd0);
    chk("rst_pmem_wdata", {63'b0, |pmem_wdata}, 64'd0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);

    // Cold read, fill after 3 wait cycles
    fw_force = 3;
    do_req(32'h0000_1004, 1'b1, 1'b0, 4'b0000, 32'h0, rd, lat);
    fw_force = -1;
    chk("cold_rdata", {32'b0, rd}, 64'hDEAD_BEEF);
    chk("cold_fill_addr", {32'b0, last_rd_addr}, 64'h0000_1000);
    chk("cold_no_wb", 64'(n_wr), 64'd0);
    chk("cold_latency", 64'(lat), 64'd7);

    // Repeat read hits in two cycles with no memory traffic
    nrd0 = n_rd;
    do_req(32'h0000_1004, 1'b1, 1'b0, 4'b0000, 32'h0, rd, lat);
    chk("hit_latency", 64'(lat), 64'd2);
    chk("hit_no_pmem", 64'(n_rd), 64'(nrd0));
    chk("hit_rdata", {32'b0, rd}, 64'hDEAD_BEEF);

    // Partial write on upper half-word, then read back
    do_req(32'h0000_1006, 1'b0, 1'b1, 4'b1100, 32'hAABB_0000, rd, lat);
    do_req(32'h0000_1004, 1'b1, 1'b0, 4'b0000, 32'h0, rd, lat);
    chk("merge_rdata", {32'b0, rd}, 64'hAABB_BEEF);

    // Conflict miss evicts the dirty line
    nwr0 = n_wr;
    do_req(32'h0000_2004, 1'b1, 1'b0, 4'b0000, 32'h0, rd, lat);
    chk("evict_wb_count", 64'(n_wr), 64'(nwr0 + 1));
    chk("evict_wb_addr", {32'b0, last_wr_addr}, 64'h0000_1000);
    chk("evict_wb_word1", {32'b0, last_wr_data[63:32]}, 64'hAABB_BEEF);
    chk("evict_fill_addr", {32'b0, last_rd_addr}, 64'h0000_2000);

    // Read and write together behave as a write
    do_req(32'h0000_2008, 1'b1, 1'b1, 4'b1111, 32'h1234_5678, rd, lat);
    do_req(32'h0000_2008, 1'b1, 1'b0, 4'b0000, 32'h0, rd, lat);
    chk("rdwr_as_write", {32'b0, rd}, 64'h1234_5678);

    // Reset in the middle of a fill
    op.wr = 1'b0; op.addr = 32'h0000_3020; op.data = mem_line(32'h0000_3020); op.wait_c = 40;
    op_q.push_back(op);
    @(posedge clk); #1;
    mem_address = 32'h0000_3024; mem_read = 1'b1; mem_write = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (pmem_read) seen = 1'b1;
    end
    chk("alloc_started", {63'b0, seen}, 64'd1);
    chk("alloc_addr", {32'b0, pmem_address}, 64'h0000_3020);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_pmem_read",  {63'b0, pmem_read}, 64'd0);
    chk("rst_mid_pmem_write", {63'b0, pmem_write}, 64'd0);
    chk("rst_mid_mem_resp",   {63'b0, mem_resp}, 64'd0);
    mem_read = 1'b0;
    op_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    nrd0 = n_rd;
    do_req(32'h0000_3024, 1'b1, 1'b0, 4'b0000, 32'h0, rd, lat);
    chk("post_rst_miss", 64'(n_rd), 64'(nrd0 + 1));
    chk("post_rst_fill_addr", {32'b0, last_rd_addr}, 64'h0000_3020);
    // Dirty data written before the reset was never written back
    do_req(32'h0000_2008, 1'b1, 1'b0, 4'b0000, 32'h0, rd, lat);

    // Randomized traffic over a few tags per set to force hits, clean and dirty misses
    for (int n = 0; n < 300; n++) begin
      a = {22'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      k = $urandom_range(0, 3);
      do_req(a, (k != 2), (k >= 2), 4'($urandom_range(0, 15)), $urandom, rd, lat);
    end

    repeat (4) @(posedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("op_q_drained", 64'(op_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
